// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection sequencer: state codes and the
// one-hot {R,Y,G} lamp encodings used for both the main and side streets.
// -----------------------------------------------------------------------------
package traffic_pkg;

    // Codes are visible on state_out, so they are pinned explicitly.
    // Code 7 has no state; the FSM recovers to MAIN_GREEN from it.
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_HOLD   = 3'd1,
        MAIN_YELLOW = 3'd2,
        WALK        = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_EXT    = 3'd5,
        SIDE_YELLOW = 3'd6
    } state_t;

    // Lamp encodings, bit order {R,Y,G}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_light_fsm_state_timer.sv
// -----------------------------------------------------------------------------
// state_timer
// Per-state dwell timer: a prescaler that divides clk down to one-second
// ticks, and a seconds counter advanced by each tick. o_expired flags the
// final clock cycle of a dwell of i_duration seconds.
//
// Ports:
//   clk         in   system clock
//   sys_reset   in   synchronous active-high reset
//   i_clear     in   restart timing (asserted on every state change)
//   i_duration  in   dwell length of the current state, in seconds (>=1)
//   o_expired   out  high on the last cycle of the dwell
// -----------------------------------------------------------------------------
module state_timer #(
    parameter int CLKS_PER_SEC = 2,
    parameter int TIMER_W      = 8
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic               i_clear,
    input  logic [TIMER_W-1:0] i_duration,
    output logic               o_expired
);

    localparam int PS_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_SEC - 1);

    logic [PS_W-1:0]    r_prescaler;
    logic [TIMER_W-1:0] r_seconds;
    logic               w_tick;

    // With CLKS_PER_SEC=1 the prescaler sits at 0 == PS_LAST, so every
    // cycle is a tick and durations count in cycles.
    assign w_tick    = (r_prescaler == PS_LAST);
    assign o_expired = w_tick && (r_seconds == i_duration - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (sys_reset || i_clear) begin
            r_prescaler <= '0;
            r_seconds   <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
            r_seconds   <= r_seconds + 1'b1;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
// Master sequencer for the intersection. Steps through the main/side/walk
// phases using a per-state seconds timer, the side-street car sensor and the
// latched pedestrian request, and clears the walk register while walking.
//
// Ports:
//   clk                  in   system clock, rising edge
//   sys_reset            in   synchronous active-high reset
//   sensor_in            in   side-street car present
//   walkRegister_status  in   latched pedestrian request
//   walkRegister_reset   out  clears the walk register, high in every WALK cycle
//   main_lights          out  main-street lamp {R,Y,G}, one-hot
//   side_lights          out  side-street lamp {R,Y,G}, one-hot
//   walk_light           out  pedestrian walk lamp
//   state_out            out  current state code (debug)
// -----------------------------------------------------------------------------
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int CLKS_PER_SEC = 2,
    parameter int T_BASE       = 6,
    parameter int T_EXT        = 3,
    parameter int T_YEL        = 2,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic       sensor_in,
    input  logic       walkRegister_status,
    output logic       walkRegister_reset,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_light,
    output logic [2:0] state_out
);

    localparam logic [TIMER_W-1:0] D_BASE = TIMER_W'(T_BASE);
    localparam logic [TIMER_W-1:0] D_EXT  = TIMER_W'(T_EXT);
    localparam logic [TIMER_W-1:0] D_YEL  = TIMER_W'(T_YEL);

    state_t             r_state;
    state_t             w_next_state;
    logic [TIMER_W-1:0] w_duration;
    logic               w_expired;
    logic               w_clear;

    // Any state change restarts the timer so the new state gets its full dwell.
    assign w_clear = (w_next_state != r_state);

    state_timer #(
        .CLKS_PER_SEC (CLKS_PER_SEC),
        .TIMER_W      (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .sys_reset  (sys_reset),
        .i_clear    (w_clear),
        .i_duration (w_duration),
        .o_expired  (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (sys_reset) r_state <= MAIN_GREEN;
        else           r_state <= w_next_state;
    end

    // Next-state and dwell selection. Inputs only matter on the expiry cycle.
    // NOTE: every combinational output gets a default first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_duration   = D_BASE;
        case (r_state)
            MAIN_GREEN: begin
                w_duration = D_BASE;
                if (w_expired) w_next_state = sensor_in ? MAIN_YELLOW : MAIN_HOLD;
            end
            MAIN_HOLD: begin
                w_duration = D_BASE;
                if (w_expired) w_next_state = MAIN_YELLOW;
            end
            MAIN_YELLOW: begin
                w_duration = D_YEL;
                if (w_expired) w_next_state = walkRegister_status ? WALK : SIDE_GREEN;
            end
            WALK: begin
                w_duration = D_EXT;
                if (w_expired) w_next_state = SIDE_GREEN;
            end
            SIDE_GREEN: begin
                w_duration = D_BASE;
                if (w_expired) w_next_state = sensor_in ? SIDE_EXT : SIDE_YELLOW;
            end
            SIDE_EXT: begin
                w_duration = D_EXT;
                if (w_expired) w_next_state = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                w_duration = D_YEL;
                if (w_expired) w_next_state = MAIN_GREEN;
            end
            // Unused code 7: leave on the next edge regardless of the timer.
            default: w_next_state = MAIN_GREEN;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        main_lights        = RED;
        side_lights        = RED;
        walk_light         = 1'b0;
        walkRegister_reset = 1'b0;
        case (r_state)
            MAIN_GREEN, MAIN_HOLD: main_lights = GRN;
            MAIN_YELLOW:           main_lights = YEL;
            WALK: begin
                walk_light         = 1'b1;
                walkRegister_reset = 1'b1;
            end
            SIDE_GREEN, SIDE_EXT:  side_lights = GRN;
            SIDE_YELLOW:           side_lights = YEL;
            default: ;
        endcase
    end

    assign state_out = r_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_fsm
// Directed bench for traffic_light_fsm: default timing instance plus a
// one-cycle-per-state instance. Inputs change and outputs are observed on the
// falling edge; "cycle n" is the window just before rising edge n, with edge 0
// the first edge after sys_reset is released.
// -----------------------------------------------------------------------------
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic       sensor_in;
    logic       walk_status;
    logic       walk_reset;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_light;
    logic [2:0] state_out;

    logic       f_reset;
    logic       f_walk_reset;
    logic [2:0] f_main;
    logic [2:0] f_side;
    logic       f_walk_light;
    logic [2:0] f_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk                 (clk),
        .sys_reset           (sys_reset),
        .sensor_in           (sensor_in),
        .walkRegister_status (walk_status),
        .walkRegister_reset  (walk_reset),
        .main_lights         (main_lights),
        .side_lights         (side_lights),
        .walk_light          (walk_light),
        .state_out           (state_out)
    );

    traffic_light_fsm #(
        .CLKS_PER_SEC (1),
        .T_BASE       (1),
        .T_EXT        (1),
        .T_YEL        (1),
        .TIMER_W      (8)
    ) dut_fast (
        .clk                 (clk),
        .sys_reset           (f_reset),
        .sensor_in           (1'b1),
        .walkRegister_status (1'b1),
        .walkRegister_reset  (f_walk_reset),
        .main_lights         (f_main),
        .side_lights         (f_side),
        .walk_light          (f_walk_light),
        .state_out           (f_state)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_main(input int s);
        if (s == 0 || s == 1) return 3'b001;
        if (s == 2)           return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_side(input int s);
        if (s == 4 || s == 5) return 3'b001;
        if (s == 6)           return 3'b010;
        return 3'b100;
    endfunction

    task automatic check_state(input string tag, input int s);
        check({tag, ".state"}, 8'(state_out),   8'(s));
        check({tag, ".main"},  8'(main_lights), 8'(exp_main(s)));
        check({tag, ".side"},  8'(side_lights), 8'(exp_side(s)));
        check({tag, ".walk"},  8'(walk_light),  8'(s == 3));
        check({tag, ".wrst"},  8'(walk_reset),  8'(s == 3));
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) next_cycle();
    endtask

    // Holds reset for two edges, then leaves us in the cycle-0 window.
    task automatic do_reset(input logic sens, input logic walk);
        @(negedge clk);
        sys_reset   = 1'b1;
        sensor_in   = sens;
        walk_status = walk;
        @(negedge clk);
        @(negedge clk);
        sys_reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        sys_reset   = 1'b1;
        sensor_in   = 1'b0;
        walk_status = 1'b0;
        f_reset     = 1'b1;

        // ---- 1: no sensor, no walk: full 44-cycle period ----
        do_reset(1'b0, 1'b0);
        check_state("reset", 0);
        while (cyc < 44) begin
            check("main_onehot", 8'($onehot(main_lights)), 8'd1);
            check("side_onehot", 8'($onehot(side_lights)), 8'd1);
            if (cyc == 11) check_state("idle.mg_end", 0);
            if (cyc == 12) check_state("idle.mh", 1);
            if (cyc == 23) check_state("idle.mh_end", 1);
            if (cyc == 24) check_state("idle.my", 2);
            if (cyc == 27) check_state("idle.my_end", 2);
            if (cyc == 28) check_state("idle.sg", 4);
            if (cyc == 39) check_state("idle.sg_end", 4);
            if (cyc == 40) check_state("idle.sy", 6);
            if (cyc == 43) check_state("idle.sy_end", 6);
            next_cycle();
        end
        check_state("idle.wrap", 0);

        // ---- 2: sensor held high ----
        do_reset(1'b1, 1'b0);
        goto(11); check_state("sens.mg_end", 0);
        goto(12); check_state("sens.my", 2);
        goto(16); check_state("sens.sg", 4);
        goto(27); check_state("sens.sg_end", 4);
        goto(28); check_state("sens.se", 5);
        goto(33); check_state("sens.se_end", 5);
        goto(34); check_state("sens.sy", 6);
        goto(38); check_state("sens.mg", 0);

        // ---- 3: walk held high, no sensor ----
        do_reset(1'b0, 1'b1);
        goto(27);
        while (cyc <= 34) begin
            check("walk.wrst_window", 8'(walk_reset), 8'(cyc >= 28 && cyc <= 33));
            if (cyc == 28) check_state("walk.start", 3);
            if (cyc == 33) check_state("walk.end", 3);
            next_cycle();
        end
        check_state("walk.sg", 4);

        // ---- 4a: sensor pulsed at cycle 10 only: ignored ----
        do_reset(1'b0, 1'b0);
        goto(10); sensor_in = 1'b1;
        next_cycle(); sensor_in = 1'b0;
        goto(12); check_state("pulse10.mh", 1);

        // ---- 4b: sensor pulsed at cycle 11 only: sampled at expiry ----
        do_reset(1'b0, 1'b0);
        goto(11); sensor_in = 1'b1;
        next_cycle(); sensor_in = 1'b0;
        check_state("pulse11.my", 2);

        // ---- 4c: walk raised at cycle 30, served at the next yellow exit ----
        do_reset(1'b0, 1'b0);
        goto(28); check_state("late.sg", 4);
        goto(30); walk_status = 1'b1;
        goto(44); check_state("late.mg", 0);
        goto(71); check_state("late.my_end", 2);
        goto(72); check_state("late.walk", 3);
        goto(78); check_state("late.sg2", 4);

        // ---- 5: reset in the middle of WALK ----
        do_reset(1'b0, 1'b1);
        goto(30); check_state("rst.walk", 3);
        sys_reset = 1'b1;
        next_cycle();
        check_state("rst.after", 0);
        sys_reset = 1'b0;
        cyc = 0;
        walk_status = 1'b0;
        goto(11); check_state("rst.mg_end", 0);
        goto(12); check_state("rst.mh", 1);

        // ---- 6: one-cycle-per-state instance, sensor and walk high ----
        @(negedge clk);
        f_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        f_reset = 1'b0;
        cyc = 0;
        begin
            int seq [7] = '{0, 2, 3, 4, 5, 6, 0};
            for (int i = 0; i < 7; i++) begin
                check("fast.state", 8'(f_state), 8'(seq[i]));
                if (seq[i] == 3) begin
                    check("fast.walk", 8'(f_walk_light), 8'd1);
                    check("fast.wrst", 8'(f_walk_reset), 8'd1);
                    check("fast.main", 8'(f_main), 8'h4);
                    check("fast.side", 8'(f_side), 8'h4);
                end
                next_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

- Master sequencer for the intersection.
- Drives main-street, side-street and pedestrian walk lamps from a per-state seconds timer, a side-street car sensor and the latched pedestrian request from the walk register.
- Is the only block that clears the walk register once a walk phase has been served.
- Sits between the walk register and the lamp drivers.

## Interface
Parameters:
- CLKS_PER_SEC, 2: clk cycles per timer second (≥1)
- T_BASE, 6: base green time, seconds (≥1)
- T_EXT, 3: side-green extension and walk time, seconds (≥1)
- T_YEL, 2: yellow time, seconds (≥1)
- TIMER_W, 8: seconds-counter width; must hold max(T_BASE, T_EXT, T_YEL)-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- sys_reset  in  1  synchronous, active-high reset
- sensor_in  in  1  side-street car present
- walkRegister_status  in  1  latched pedestrian request
- walkRegister_reset  out  1  clears walk register; high in every WALK cycle
- main_lights  out  3  {R,Y,G}, one-hot
- side_lights  out  3  {R,Y,G}, one-hot
- walk_light  out  1  pedestrian walk lamp
- state_out  out  3  current state code, for debug

## Operation
States and codes, with dwell time and exit rule:
- MAIN_GREEN (0): T_BASE. At expiry: sensor_in=1 → MAIN_YELLOW, else MAIN_HOLD.
- MAIN_HOLD (1): T_BASE → MAIN_YELLOW.
- MAIN_YELLOW (2): T_YEL. At expiry: walkRegister_status=1 → WALK, else SIDE_GREEN.
- WALK (3): T_EXT, both streets red, walk_light=1 → SIDE_GREEN.
- SIDE_GREEN (4): T_BASE. At expiry: sensor_in=1 → SIDE_EXT, else SIDE_YELLOW.
- SIDE_EXT (5): T_EXT → SIDE_YELLOW.
- SIDE_YELLOW (6): T_YEL → MAIN_GREEN.
- Code 7 unused. If reached, go to MAIN_GREEN on the next edge.

Outputs:
- All outputs are Moore outputs decoded from the state register; no input-to-output combinational path.
- Main lamp is green in MAIN_GREEN and MAIN_HOLD, yellow in MAIN_YELLOW, red otherwise.
- Side lamp is green in SIDE_GREEN and SIDE_EXT, yellow in SIDE_YELLOW, red otherwise.

Inputs:
- sensor_in and walkRegister_status are sampled only on the expiry cycle of the state that tests them. Values at any other cycle are ignored.
- Walk requests arriving during WALK are cleared by walkRegister_reset and are not served again.

## Timing
- Reset values:
  - state MAIN_GREEN
  - main_lights=3'b001
  - side_lights=3'b100
  - walk_light=0
  - walkRegister_reset=0
  - state_out=0
  - prescaler=0, seconds counter=0
- Prescaler counts 0..CLKS_PER_SEC-1. tick is high when prescaler = CLKS_PER_SEC-1.
- Seconds counter increments on tick.
- Expiry is tick with seconds = duration-1. The state changes on that edge.
- Prescaler and seconds counter both clear on every state change. Each state therefore lasts exactly duration×CLKS_PER_SEC cycles.
- sys_reset wins over everything, including mid-state and mid-WALK. On the next edge, all registers take reset values. walkRegister_reset drops immediately.
- CLKS_PER_SEC=1: tick is constantly high and durations are counted in cycles.

## Structure
- Package traffic_pkg holds:
  - state enum and codes
  - lamp encodings: RED=3'b100, YEL=3'b010, GRN=3'b001
- One sub-module, state_timer:
  - prescaler plus seconds counter
  - inputs: clear, duration
  - output: expired
- Remaining logic is the next-state and output decode in traffic_light_fsm.

## Test plan
Defaults apply; cycle 0 is the first edge after sys_reset is released.
- No sensor, no walk:
  - MAIN_GREEN 0–11, MAIN_HOLD 12–23, MAIN_YELLOW 24–27, SIDE_GREEN 28–39, SIDE_YELLOW 40–43, MAIN_GREEN at 44.
  - Period 44 cycles; lamps one-hot throughout.
- sensor_in held 1:
  - MAIN_YELLOW at 12, SIDE_GREEN at 16, SIDE_EXT at 28, SIDE_YELLOW at 34, MAIN_GREEN at 38.
- walkRegister_status held 1, no sensor:
  - WALK during 28–33 with walk_light=1, both lamps 3'b100, walkRegister_reset=1 on exactly those 6 cycles.
  - SIDE_GREEN at 34.
- Sampling window:
  - sensor_in pulsed only at cycle 10 → MAIN_HOLD at 12.
  - sensor_in pulsed only at cycle 11 → MAIN_YELLOW at 12.
  - walkRegister_status raised at cycle 30 → no WALK until the next MAIN_YELLOW exit at cycle 72.
- sys_reset asserted at cycle 30 during WALK:
  - next edge gives MAIN_GREEN, walk_light=0, walkRegister_reset=0.
  - Timing restarts from 0 after release.
- CLKS_PER_SEC=1, T_BASE=1, T_EXT=1, T_YEL=1, sensor and walk high:
  - one cycle per state; sequence 0,2,3,4,5,6,0.
